// File: rtl/stream_consumer_if.sv
// Dual-lane address/id stream with flush, plus the single retire port.
// master drives lanes/flush/ready; slave is the consumer.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

interface stream_consumer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                      in_valid_1;
  logic                      in_valid_2;
  logic [`ADDRESS_WIDTH-1:0] in_address_1;
  logic [`ADDRESS_WIDTH-1:0] in_address_2;
  logic [`ID_WIDTH-1:0]      in_id_1;
  logic [`ID_WIDTH-1:0]      in_id_2;
  logic                      out_stall_1;
  logic                      out_stall_2;
  logic                      flush_1;
  logic                      flush_2;
  logic [`ID_WIDTH-1:0]      flush_id_1;
  logic [`ID_WIDTH-1:0]      flush_id_2;
  logic                      retire_ready;
  logic                      retire_valid;
  logic                      retire_lane;
  logic [`ADDRESS_WIDTH-1:0] retire_address;
  logic [`ID_WIDTH-1:0]      retire_id;
  logic [CNT_WIDTH-1:0]      retire_count;
  logic [CNT_WIDTH-1:0]      squash_count_1;
  logic [CNT_WIDTH-1:0]      squash_count_2;

  modport master (
    output in_valid_1, in_valid_2,
    output in_address_1, in_address_2,
    output in_id_1, in_id_2,
    output flush_1, flush_2,
    output flush_id_1, flush_id_2,
    output retire_ready,
    input  out_stall_1, out_stall_2,
    input  retire_valid, retire_lane,
    input  retire_address, retire_id,
    input  retire_count,
    input  squash_count_1, squash_count_2
  );

  modport slave (
    input  in_valid_1, in_valid_2,
    input  in_address_1, in_address_2,
    input  in_id_1, in_id_2,
    input  flush_1, flush_2,
    input  flush_id_1, flush_id_2,
    input  retire_ready,
    output out_stall_1, out_stall_2,
    output retire_valid, retire_lane,
    output retire_address, retire_id,
    output retire_count,
    output squash_count_1, squash_count_2
  );
endinterface

// File: rtl/stream_consumer.sv
// Per-lane FIFOs with id flush, one registered global stall,
// and a round-robin show-ahead retire port.
module stream_consumer #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  stream_consumer_if.slave s
);
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [2][DEPTH];
  logic [IW-1:0] id_q   [2][DEPTH];
  logic          live_q [2][DEPTH];
  logic          live_d [2][DEPTH];
  logic [PW-1:0] rp_q   [2];
  logic [PW-1:0] wp_q   [2];
  logic [PW:0]   occ_q  [2];
  logic [PW:0]   occ_d  [2];
  logic [CNT_WIDTH-1:0] sq_q [2];
  logic [CNT_WIDTH-1:0] sq_d [2];
  logic [CNT_WIDTH-1:0] rcnt_q;
  logic stall_q, rr_q, lock_q, lsel_q;

  logic          in_v  [2];
  logic [AW-1:0] in_a  [2];
  logic [IW-1:0] in_id [2];
  logic          fl    [2];
  logic [IW-1:0] fl_id [2];

  assign in_v[0]  = s.in_valid_1;
  assign in_v[1]  = s.in_valid_2;
  assign in_a[0]  = s.in_address_1;
  assign in_a[1]  = s.in_address_2;
  assign in_id[0] = s.in_id_1;
  assign in_id[1] = s.in_id_2;
  assign fl[0]    = s.flush_1;
  assign fl[1]    = s.flush_2;
  assign fl_id[0] = s.flush_id_1;
  assign fl_id[1] = s.flush_id_2;

  logic elig [2];
  logic dead [2];
  logic push [2];
  logic pop  [2];
  logic hit  [2];
  logic sel, rvalid, fire, stall_d;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      elig[n] = (|occ_q[n]) && live_q[n][rp_q[n]];
      dead[n] = (|occ_q[n]) && !live_q[n][rp_q[n]];
      push[n] = in_v[n] && !stall_q;
      hit[n]  = fl[n] && (in_id[n] == fl_id[n]);
    end
  end

  // A word held under back-pressure keeps its lane until taken
  always_comb begin
    if (lock_q && elig[lsel_q])
      sel = lsel_q;
    else if (elig[0] && elig[1])
      sel = rr_q;
    else
      sel = elig[1];
    rvalid = elig[0] || elig[1];
    fire   = rvalid && s.retire_ready;
    pop[0] = dead[0] || (fire && !sel);
    pop[1] = dead[1] || (fire && sel);
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      sq_d[n] = sq_q[n];
      for (int i = 0; i < DEPTH; i++) begin
        live_d[n][i] = live_q[n][i];
        if (fl[n] && live_q[n][i]
            && ({1'b0, PW'(i) - rp_q[n]} < occ_q[n])
            && (id_q[n][i] == fl_id[n])
            && !(pop[n] && (PW'(i) == rp_q[n]))) begin
          live_d[n][i] = 1'b0;
          sq_d[n] = sq_d[n] + CNT_WIDTH'(1);
        end
      end
      if (push[n] && hit[n])
        sq_d[n] = sq_d[n] + CNT_WIDTH'(1);
      occ_d[n] = occ_q[n] + (PW+1)'(push[n])
                 - (PW+1)'(pop[n]);
    end
    stall_d = (occ_d[0] == (PW+1)'(DEPTH))
           || (occ_d[1] == (PW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++)
      if (push[n]) begin
        addr_q[n][wp_q[n]] <= in_a[n];
        id_q[n][wp_q[n]]   <= in_id[n];
      end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < 2; n++) begin
        for (int i = 0; i < DEPTH; i++)
          live_q[n][i] <= 1'b0;
        rp_q[n]  <= '0;
        wp_q[n]  <= '0;
        occ_q[n] <= '0;
        sq_q[n]  <= '0;
      end
      rcnt_q  <= '0;
      stall_q <= 1'b0;
      rr_q    <= 1'b0;
      lock_q  <= 1'b0;
      lsel_q  <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        for (int i = 0; i < DEPTH; i++)
          live_q[n][i] <= live_d[n][i];
        if (push[n]) begin
          live_q[n][wp_q[n]] <= !hit[n];
          wp_q[n] <= wp_q[n] + PW'(1);
        end
        if (pop[n])
          rp_q[n] <= rp_q[n] + PW'(1);
        occ_q[n] <= occ_d[n];
        sq_q[n]  <= sq_d[n];
      end
      if (fire) begin
        rcnt_q <= rcnt_q + CNT_WIDTH'(1);
        rr_q   <= !sel;
      end
      stall_q <= stall_d;
      lock_q  <= rvalid && !s.retire_ready;
      lsel_q  <= sel;
    end
  end

  assign s.out_stall_1    = stall_q;
  assign s.out_stall_2    = stall_q;
  assign s.retire_valid   = rvalid;
  assign s.retire_lane    = sel;
  assign s.retire_address = addr_q[sel][rp_q[sel]];
  assign s.retire_id      = id_q[sel][rp_q[sel]];
  assign s.retire_count   = rcnt_q;
  assign s.squash_count_1 = sq_q[0];
  assign s.squash_count_2 = sq_q[1];
endmodule

// File: tb/tb_stream_consumer.sv
// Directed bench for stream_consumer: fill, flush, round-robin,
// same-edge flush, back-pressure and mid-stream reset.
module tb_stream_consumer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  stream_consumer_if #(.CNT_WIDTH(16)) bus ();

  stream_consumer #(
    .DEPTH(4),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lane1(input logic v, input logic [7:0] id);
    bus.in_valid_1   = v;
    bus.in_id_1      = id;
    bus.in_address_1 = 32'h1000 + 32'(id);
  endtask

  task automatic lane2(input logic v, input logic [7:0] id);
    bus.in_valid_2   = v;
    bus.in_id_2      = id;
    bus.in_address_2 = 32'h1000 + 32'(id);
  endtask

  initial begin
    lane1(1'b0, 8'h00);
    lane2(1'b0, 8'h00);
    bus.flush_1 = 1'b0;
    bus.flush_2 = 1'b0;
    bus.flush_id_1 = '0;
    bus.flush_id_2 = '0;
    bus.retire_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(bus.retire_valid), 0);
    chk("rst_stall", 32'(bus.out_stall_1), 0);
    chk("rst_rcnt", 32'(bus.retire_count), 0);
    chk("rst_sq1", 32'(bus.squash_count_1), 0);
    chk("rst_sq2", 32'(bus.squash_count_2), 0);
    reset = 1'b1;

    // fill lane 1 with retire_ready low
    lane1(1'b1, 8'h11);
    step();
    chk("fill_lat_valid", 32'(bus.retire_valid), 1);
    chk("fill_lat_id", 32'(bus.retire_id), 32'h11);
    chk("fill_lat_lane", 32'(bus.retire_lane), 0);
    chk("fill_stall0", 32'(bus.out_stall_1), 0);
    lane1(1'b1, 8'h12);
    step();
    lane1(1'b1, 8'h13);
    step();
    chk("fill_stall3", 32'(bus.out_stall_1), 0);
    lane1(1'b1, 8'h14);
    step();
    chk("fill_stall1", 32'(bus.out_stall_1), 1);
    chk("fill_stall2", 32'(bus.out_stall_2), 1);
    lane1(1'b1, 8'h15);
    lane2(1'b1, 8'h21);
    step();
    step();
    chk("fill_hold_stall", 32'(bus.out_stall_1), 1);
    chk("fill_hold_id", 32'(bus.retire_id), 32'h11);
    chk("fill_hold_addr", bus.retire_address, 32'h1011);
    lane1(1'b0, 8'h00);
    lane2(1'b0, 8'h00);

    // flush 0x14, then drain lane 1
    bus.flush_1 = 1'b1;
    bus.flush_id_1 = 8'h14;
    step();
    bus.flush_1 = 1'b0;
    chk("flush_sq1", 32'(bus.squash_count_1), 1);
    bus.retire_ready = 1'b1;
    chk("drain_id0", 32'(bus.retire_id), 32'h11);
    step();
    chk("drain_stall", 32'(bus.out_stall_1), 0);
    chk("drain_id1", 32'(bus.retire_id), 32'h12);
    step();
    chk("drain_id2", 32'(bus.retire_id), 32'h13);
    step();
    chk("drain_dead_valid", 32'(bus.retire_valid), 0);
    step();
    chk("drain_empty_valid", 32'(bus.retire_valid), 0);
    chk("drain_rcnt", 32'(bus.retire_count), 3);

    // round-robin: rr now points at lane 2 after three pops
    bus.retire_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lane1(1'b1, 8'(8'h31 + k));
      lane2(1'b1, 8'(8'h41 + k));
      step();
    end
    lane1(1'b0, 8'h00);
    lane2(1'b0, 8'h00);
    chk("rr_full_stall", 32'(bus.out_stall_1), 1);
    bus.retire_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("rr_lane", 32'(bus.retire_lane), (j % 2 == 0) ? 1 : 0);
      chk("rr_id", 32'(bus.retire_id),
          (j % 2 == 0) ? 32'h41 + j / 2 : 32'h31 + j / 2);
      step();
      if (j == 0) chk("rr_stall_j0", 32'(bus.out_stall_1), 1);
      if (j == 1) chk("rr_stall_j1", 32'(bus.out_stall_1), 0);
    end
    chk("rr_rcnt", 32'(bus.retire_count), 11);
    chk("rr_empty", 32'(bus.retire_valid), 0);

    // flush and push of the same id on one edge
    bus.retire_ready = 1'b0;
    lane1(1'b1, 8'h15);
    bus.flush_1 = 1'b1;
    bus.flush_id_1 = 8'h15;
    step();
    lane1(1'b0, 8'h00);
    bus.flush_1 = 1'b0;
    chk("same_valid", 32'(bus.retire_valid), 0);
    chk("same_sq1", 32'(bus.squash_count_1), 2);
    step();
    lane1(1'b1, 8'h16);
    step();
    lane1(1'b0, 8'h00);
    chk("same_next_id", 32'(bus.retire_id), 32'h16);

    // back-pressure; lane 2 arrives while rr favours it
    lane2(1'b1, 8'h51);
    step();
    lane2(1'b0, 8'h00);
    for (int j = 0; j < 3; j++) begin
      chk("bp_valid", 32'(bus.retire_valid), 1);
      chk("bp_lane", 32'(bus.retire_lane), 0);
      chk("bp_id", 32'(bus.retire_id), 32'h16);
      chk("bp_addr", bus.retire_address, 32'h1016);
      chk("bp_rcnt", 32'(bus.retire_count), 11);
      step();
    end
    bus.retire_ready = 1'b1;
    step();
    bus.retire_ready = 1'b0;
    chk("bp_pop_rcnt", 32'(bus.retire_count), 12);
    chk("bp_next_lane", 32'(bus.retire_lane), 1);
    chk("bp_next_id", 32'(bus.retire_id), 32'h51);

    // reset with both lanes half full
    lane1(1'b1, 8'h61);
    lane2(1'b1, 8'h52);
    step();
    lane2(1'b0, 8'h00);
    lane1(1'b1, 8'h62);
    step();
    lane1(1'b0, 8'h00);
    bus.retire_ready = 1'b1;
    reset = 1'b0;
    step();
    chk("mrst_valid", 32'(bus.retire_valid), 0);
    chk("mrst_stall", 32'(bus.out_stall_1), 0);
    chk("mrst_rcnt", 32'(bus.retire_count), 0);
    chk("mrst_sq1", 32'(bus.squash_count_1), 0);
    reset = 1'b1;
    step();
    step();
    chk("mrst_stale", 32'(bus.retire_valid), 0);
    chk("mrst_rcnt2", 32'(bus.retire_count), 0);
    bus.retire_ready = 1'b0;
    lane2(1'b1, 8'h71);
    step();
    lane2(1'b0, 8'h00);
    chk("mrst_new_lane", 32'(bus.retire_lane), 1);
    chk("mrst_new_id", 32'(bus.retire_id), 32'h71);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
